multi_target_select: RTL and testbench
======================================

MULTI_TARGET_SELECT -- requirements
Module: multi_target_select

Interface
REQ-001 The block SHALL have one clock and one reset: clk_65mhz, and reset, which is synchronous and active-high.
REQ-002 Parameters (name, default, meaning), one per line:
- NUM_TARGETS, 2: number of colour targets captured, range 1..4.
- SAMPLE_LOG2, 1: sample window is W x W pixels with W = 2^SAMPLE_LOG2, range 0..3.
- CURSOR_STEP, 3: cursor pixels moved per frame.
- H_MAX, 320: active width.
- V_MAX, 240: active height.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk_65mhz, in, 1: pixel clock.
- reset, in, 1: synchronous active-high reset.
- hcount, in, 11: raster column.
- vcount, in, 10: raster row.
- frame_tick, in, 1: one-cycle pulse per frame.
- dir, in, 4: {up,down,left,right}, already debounced levels.
- confirm, in, 1: debounced level.
- cancel, in, 1: debounced level.
- start, in, 1: debounced level.
- cam, in, 12: RGB444 pixel aligned to hcount/vcount.
- cur_rad, in, 7: current tracked blob radius.
- cursor_x, out, 11: cursor column.
- cursor_y, out, 10: cursor row.
- sample_pixel, out, 12: latest window average.
- sample_valid, out, 1: one-cycle pulse on sample update.
- goal_pixel, out, 12*NUM_TARGETS: captured colours, target i at bits [12i+11:12i].
- goal_rad, out, 7*NUM_TARGETS: captured radii, same packing.
- target_valid, out, NUM_TARGETS: per-target captured flag.
- active_idx, out, 2: target currently being selected.
- state, out, 2: FSM state.
- track, out, 1: tracking enable.
- move, out, 1: motion enable.

Function
REQ-004 Cursor SHALL update only in cycles where frame_tick=1 and state is AIM or HOLD: position moves by ±CURSOR_STEP and clamps to [0, H_MAX-W] and [0, V_MAX-W].
REQ-005 Opposing directions asserted together (up+down, or left+right) SHALL produce no motion on that axis.
REQ-006 The sample window SHALL be columns cursor_x..cursor_x+W-1 by rows cursor_y..cursor_y+W-1; inside it, per-channel sums SHALL accumulate with width 4+2*SAMPLE_LOG2 and no overflow.
REQ-007 On the cycle hcount=cursor_x+W-1 and vcount=cursor_y+W-1, the block SHALL register sample_pixel = each channel sum >> (2*SAMPLE_LOG2) (truncating), with 1-cycle latency, and pulse sample_valid for one cycle.
REQ-008 Accumulators SHALL clear on frame_tick. A cursor move SHALL clear sample_seen; sample_seen sets on the next sample_valid.
REQ-009 confirm, cancel and start SHALL be rising-edge detected internally; only edges act.
REQ-010 States SHALL be AIM=0, HOLD=1, LOCKED=2, RUN=3. Outputs per state:
- AIM: track=0, move=0.
- HOLD and LOCKED: track=1, move=0.
- RUN: track=1, move=1.
REQ-011 AIM: a confirm edge with sample_seen=1 SHALL latch candidate=sample_pixel and go to HOLD; a confirm edge with sample_seen=0 SHALL be ignored.
REQ-012 HOLD: a confirm edge SHALL write goal_pixel[active_idx]=candidate and goal_rad[active_idx]=cur_rad and set target_valid[active_idx]. Then:
- if active_idx=NUM_TARGETS-1, go to LOCKED;
- otherwise increment active_idx and go to AIM.
Any dir bit asserted, or a cancel edge, SHALL return to AIM with nothing written.
REQ-013 LOCKED: a start edge SHALL go to RUN. RUN: start deasserted SHALL return to LOCKED.
REQ-014 A cancel edge in LOCKED or RUN SHALL clear target_valid, goal_pixel and goal_rad, zero active_idx, and go to AIM.
REQ-015 Simultaneous events SHALL resolve in this priority: cancel > dir > confirm > start.
REQ-016 Goals SHALL remain stable in RUN regardless of cursor or cam activity.

Reset
REQ-017 While reset=1, state SHALL be AIM, cursor SHALL be (15,15), and the following SHALL be zero: sample_pixel, sample_valid, goal_pixel, goal_rad, target_valid, active_idx, track, move, sample_seen, accumulators and edge-detect history.
REQ-018 Reset mid-frame SHALL suppress sample_valid until a full window completes after the next frame_tick.

Structure
REQ-019 A shared package tracker_pkg SHALL hold the state enum, pixel_t (12-bit), and the RGB444 channel index constants.
REQ-020 Window accumulation and averaging (REQ-006..REQ-008) SHALL be one sub-module, window_sampler, parametrised by SAMPLE_LOG2.

Verification
REQ-021 Reset, then 4 frame_ticks with right held -> cursor_x=27, cursor_y=15.
REQ-022 SAMPLE_LOG2=1, cam=0xF84 inside the window -> sample_pixel=0xF84 with a single sample_valid pulse per frame. Window pixels 0x000,0x000,0xFFF,0xFFF -> sample_pixel=0x777.
REQ-023 NUM_TARGETS=2: confirm,confirm with cam=0xF00, cur_rad=20, then move, sample, confirm,confirm with cam=0x0F0, cur_rad=12 -> goal_pixel={0x0F0,0xF00}, goal_rad={12,20}, target_valid=2'b11, state=LOCKED.
REQ-024 In HOLD, assert confirm edge and up in the same cycle -> state=AIM, target_valid unchanged.
REQ-025 RUN, then cancel edge -> move=0, track=0, target_valid=0, active_idx=0, state=AIM in the following cycle.
REQ-026 Hold up+down plus left at cursor_x=1 for 1 frame -> cursor_x=0, cursor_y unchanged. Confirm edge before any sample -> state stays AIM.

Source files
------------

// File: rtl/tracker_pkg.sv
// tracker_pkg: shared FSM state encoding, pixel type and RGB444 channel positions
package tracker_pkg;
  typedef enum logic [1:0] {AIM = 2'd0, HOLD = 2'd1, LOCKED = 2'd2, RUN = 2'd3} state_t;
  typedef logic [11:0] pixel_t;
  localparam int CH_B = 0;
  localparam int CH_G = 1;
  localparam int CH_R = 2;
endpackage

// File: rtl/window_sampler.sv
// window_sampler: averages the W x W pixel window at the cursor once per frame
module window_sampler import tracker_pkg::*; #(
  parameter int SAMPLE_LOG2 = 1
) (
  input  logic        clk_65mhz,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        frame_tick,
  input  logic [10:0] cursor_x,
  input  logic [9:0]  cursor_y,
  input  pixel_t      cam,
  output pixel_t      sample_pixel,
  output logic        sample_valid
);
  localparam int W = 1 << SAMPLE_LOG2;
  localparam int SW = 4 + 2 * SAMPLE_LOG2;
  logic [10:0] w_dh;
  logic [9:0] w_dv;
  logic w_in, w_last, w_fire, r_armed, r_valid;
  logic [2:0][SW-1:0] r_acc, w_sum;
  pixel_t w_avg, r_pixel;
  assign w_dh = hcount - cursor_x;
  assign w_dv = vcount - cursor_y;
  assign w_in = hcount >= cursor_x && vcount >= cursor_y && w_dh < 11'(W) && w_dv < 10'(W);
  assign w_last = w_in && w_dh == 11'(W - 1) && w_dv == 10'(W - 1);
  assign w_fire = w_last && r_armed && !frame_tick;
  assign sample_pixel = r_pixel;
  assign sample_valid = r_valid;
  // Running sums include the current pixel so the last window pixel lands in the average
  always_comb begin
    w_sum = r_acc;
    w_avg = '0;
    for (int c = CH_B; c <= CH_R; c++) begin
      w_sum[c] = r_acc[c] + SW'(cam[4*c +: 4]);
      w_avg[4*c +: 4] = 4'(w_sum[c] >> (2 * SAMPLE_LOG2));
    end
  end
  // Accumulate inside the window; only a frame that started after reset may report a sample
  always_ff @(posedge clk_65mhz) begin
    if (reset) begin
      r_acc <= '0;
      r_armed <= 1'b0;
      r_valid <= 1'b0;
      r_pixel <= '0;
    end else begin
      r_valid <= w_fire;
      if (w_fire) r_pixel <= w_avg;
      if (frame_tick) begin
        r_acc <= '0;
        r_armed <= 1'b1;
      end else if (w_in) r_acc <= w_sum;
    end
  end
endmodule

// File: rtl/multi_target_select.sv
// multi_target_select: cursor-driven colour/radius capture of up to four tracking targets
module multi_target_select import tracker_pkg::*; #(
  parameter int NUM_TARGETS = 2,
  parameter int SAMPLE_LOG2 = 1,
  parameter int CURSOR_STEP = 3,
  parameter int H_MAX = 320,
  parameter int V_MAX = 240
) (
  input  logic                     clk_65mhz,
  input  logic                     reset,
  input  logic [10:0]              hcount,
  input  logic [9:0]               vcount,
  input  logic                     frame_tick,
  input  logic [3:0]               dir,
  input  logic                     confirm,
  input  logic                     cancel,
  input  logic                     start,
  input  logic [11:0]              cam,
  input  logic [6:0]               cur_rad,
  output logic [10:0]              cursor_x,
  output logic [9:0]               cursor_y,
  output logic [11:0]              sample_pixel,
  output logic                     sample_valid,
  output logic [12*NUM_TARGETS-1:0] goal_pixel,
  output logic [7*NUM_TARGETS-1:0]  goal_rad,
  output logic [NUM_TARGETS-1:0]    target_valid,
  output logic [1:0]               active_idx,
  output logic [1:0]               state,
  output logic                     track,
  output logic                     move
);
  localparam int W = 1 << SAMPLE_LOG2;
  localparam int X_MAX = H_MAX - W;
  localparam int Y_MAX = V_MAX - W;
  localparam logic [1:0] LAST = 2'(NUM_TARGETS - 1);
  state_t r_state, w_next;
  logic [10:0] r_x, w_x;
  logic [9:0] r_y, w_y;
  int w_xi, w_yi;
  logic r_conf_d, r_canc_d, r_start_d, w_conf_e, w_canc_e, w_start_e;
  logic r_seen, w_upd, w_moved, w_latch, w_write, w_clear, w_valid;
  pixel_t r_cand, w_pixel;
  logic [12*NUM_TARGETS-1:0] r_goal_pixel;
  logic [7*NUM_TARGETS-1:0] r_goal_rad;
  logic [NUM_TARGETS-1:0] r_tv;
  logic [1:0] r_idx;
  window_sampler #(.SAMPLE_LOG2(SAMPLE_LOG2)) u_sampler (
    .clk_65mhz(clk_65mhz), .reset(reset), .hcount(hcount), .vcount(vcount),
    .frame_tick(frame_tick), .cursor_x(r_x), .cursor_y(r_y), .cam(cam),
    .sample_pixel(w_pixel), .sample_valid(w_valid)
  );
  assign w_conf_e = confirm && !r_conf_d;
  assign w_canc_e = cancel && !r_canc_d;
  assign w_start_e = start && !r_start_d;
  assign w_upd = frame_tick && (r_state == AIM || r_state == HOLD);
  assign w_moved = w_upd && (w_x != r_x || w_y != r_y);
  assign cursor_x = r_x;
  assign cursor_y = r_y;
  assign sample_pixel = w_pixel;
  assign sample_valid = w_valid;
  assign goal_pixel = r_goal_pixel;
  assign goal_rad = r_goal_rad;
  assign target_valid = r_tv;
  assign active_idx = r_idx;
  assign state = r_state;
  assign track = r_state != AIM;
  assign move = r_state == RUN;
  // Proposed cursor: opposing directions cancel, result clamped so the window stays on screen
  always_comb begin
    w_xi = int'(r_x) + (dir[0] && !dir[1] ? CURSOR_STEP : dir[1] && !dir[0] ? -CURSOR_STEP : 0);
    w_yi = int'(r_y) + (dir[2] && !dir[3] ? CURSOR_STEP : dir[3] && !dir[2] ? -CURSOR_STEP : 0);
    w_x = 11'(w_xi < 0 ? 0 : w_xi > X_MAX ? X_MAX : w_xi);
    w_y = 10'(w_yi < 0 ? 0 : w_yi > Y_MAX ? Y_MAX : w_yi);
  end
  // Next state and datapath strobes; branch order gives cancel > dir > confirm > start
  always_comb begin
    w_next = r_state;
    w_latch = 1'b0;
    w_write = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      AIM: if (w_conf_e && r_seen) begin
        w_next = HOLD;
        w_latch = 1'b1;
      end
      HOLD: if (w_canc_e || |dir) w_next = AIM;
        else if (w_conf_e) begin
          w_write = 1'b1;
          w_next = r_idx == LAST ? LOCKED : AIM;
        end
      LOCKED: if (w_canc_e) begin
        w_clear = 1'b1;
        w_next = AIM;
      end else if (w_start_e) w_next = RUN;
      RUN: if (w_canc_e) begin
        w_clear = 1'b1;
        w_next = AIM;
      end else if (!start) w_next = LOCKED;
    endcase
  end
  // State register
  always_ff @(posedge clk_65mhz) begin
    if (reset) r_state <= AIM;
    else r_state <= w_next;
  end
  // Cursor, edge history, sample bookkeeping and captured goals
  always_ff @(posedge clk_65mhz) begin
    if (reset) begin
      r_x <= 11'd15;
      r_y <= 10'd15;
      r_conf_d <= 1'b0;
      r_canc_d <= 1'b0;
      r_start_d <= 1'b0;
      r_seen <= 1'b0;
      r_cand <= '0;
      r_goal_pixel <= '0;
      r_goal_rad <= '0;
      r_tv <= '0;
      r_idx <= '0;
    end else begin
      r_conf_d <= confirm;
      r_canc_d <= cancel;
      r_start_d <= start;
      if (w_upd) begin
        r_x <= w_x;
        r_y <= w_y;
      end
      r_seen <= w_moved ? 1'b0 : w_valid ? 1'b1 : r_seen;
      if (w_latch) r_cand <= w_pixel;
      if (w_clear) begin
        r_goal_pixel <= '0;
        r_goal_rad <= '0;
        r_tv <= '0;
        r_idx <= '0;
      end else if (w_write) begin
        for (int i = 0; i < NUM_TARGETS; i++)
          if (r_idx == 2'(i)) begin
            r_goal_pixel[12*i +: 12] <= r_cand;
            r_goal_rad[7*i +: 7] <= cur_rad;
            r_tv[i] <= 1'b1;
          end
        r_idx <= r_idx == LAST ? r_idx : r_idx + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_multi_target_select.sv
// tb_multi_target_select: directed scenario checks for multi_target_select
module tb_multi_target_select;
  logic clk_65mhz = 1'b0;
  logic reset;
  logic [10:0] hcount;
  logic [9:0] vcount;
  logic frame_tick;
  logic [3:0] dir;
  logic confirm, cancel, start;
  logic [11:0] cam;
  logic [6:0] cur_rad;
  logic [10:0] cursor_x;
  logic [9:0] cursor_y;
  logic [11:0] sample_pixel;
  logic sample_valid;
  logic [23:0] goal_pixel;
  logic [13:0] goal_rad;
  logic [1:0] target_valid;
  logic [1:0] active_idx;
  logic [1:0] state;
  logic track, move;
  int n_pass = 0;
  int n_total = 0;
  always #5 clk_65mhz = ~clk_65mhz;
  multi_target_select dut (
    .clk_65mhz(clk_65mhz), .reset(reset), .hcount(hcount), .vcount(vcount),
    .frame_tick(frame_tick), .dir(dir), .confirm(confirm), .cancel(cancel),
    .start(start), .cam(cam), .cur_rad(cur_rad), .cursor_x(cursor_x),
    .cursor_y(cursor_y), .sample_pixel(sample_pixel), .sample_valid(sample_valid),
    .goal_pixel(goal_pixel), .goal_rad(goal_rad), .target_valid(target_valid),
    .active_idx(active_idx), .state(state), .track(track), .move(move)
  );
  task automatic tick();
    @(negedge clk_65mhz) frame_tick = 1'b1;
    @(negedge clk_65mhz) frame_tick = 1'b0;
  endtask
  task automatic confirm_edge();
    @(negedge clk_65mhz) confirm = 1'b1;
    @(negedge clk_65mhz) confirm = 1'b0;
  endtask
  task automatic feed(input logic with_tick, input logic [10:0] x, input logic [9:0] y,
                      input logic [11:0] p0, p1, p2, p3, output int pulses, output logic [11:0] px);
    pulses = 0;
    px = '0;
    if (with_tick) tick();
    @(negedge clk_65mhz) begin hcount = x; vcount = y; cam = p0; end
    @(negedge clk_65mhz) begin pulses += int'(sample_valid); hcount = x + 11'd1; cam = p1; end
    @(negedge clk_65mhz) begin pulses += int'(sample_valid); hcount = x; vcount = y + 10'd1; cam = p2; end
    @(negedge clk_65mhz) begin pulses += int'(sample_valid); hcount = x + 11'd1; cam = p3; end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_65mhz);
      if (i == 0) px = sample_pixel;
      pulses += int'(sample_valid);
      hcount = 11'd1000; vcount = 10'd1000; cam = 12'h000;
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk_65mhz);
    n_total += 8;
    if (cursor_x !== 11'd15) $display("FAIL reset_cursor_x: got %0d expected 15", cursor_x); else n_pass++;
    if (cursor_y !== 10'd15) $display("FAIL reset_cursor_y: got %0d expected 15", cursor_y); else n_pass++;
    if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else n_pass++;
    if (sample_valid !== 1'b0 || sample_pixel !== 12'h000) $display("FAIL reset_sample: got %0b/%h expected 0/000", sample_valid, sample_pixel); else n_pass++;
    if (goal_pixel !== 24'h0 || goal_rad !== 14'h0) $display("FAIL reset_goals: got %h/%h expected 0/0", goal_pixel, goal_rad); else n_pass++;
    if (target_valid !== 2'b00) $display("FAIL reset_target_valid: got %b expected 00", target_valid); else n_pass++;
    if (active_idx !== 2'd0) $display("FAIL reset_active_idx: got %0d expected 0", active_idx); else n_pass++;
    if (track !== 1'b0 || move !== 1'b0) $display("FAIL reset_track_move: got %b%b expected 00", track, move); else n_pass++;
    @(negedge clk_65mhz) reset = 1'b0;
  endtask
  task automatic test_no_sample_after_reset();
    int pulses;
    logic [11:0] px;
    feed(1'b0, 11'd15, 10'd15, 12'hABC, 12'hABC, 12'hABC, 12'hABC, pulses, px);
    n_total++;
    if (pulses !== 0) $display("FAIL unarmed_window_pulses: got %0d expected 0", pulses); else n_pass++;
    confirm_edge();
    n_total++;
    if (state !== 2'd0) $display("FAIL confirm_before_sample_state: got %0d expected 0", state); else n_pass++;
  endtask
  task automatic test_cursor();
    dir = 4'b0001;
    repeat (4) tick();
    dir = 4'b0000;
    n_total += 2;
    if (cursor_x !== 11'd27) $display("FAIL right4_cursor_x: got %0d expected 27", cursor_x); else n_pass++;
    if (cursor_y !== 10'd15) $display("FAIL right4_cursor_y: got %0d expected 15", cursor_y); else n_pass++;
  endtask
  task automatic test_sample();
    int pulses;
    logic [11:0] px;
    feed(1'b1, 11'd27, 10'd15, 12'hF84, 12'hF84, 12'hF84, 12'hF84, pulses, px);
    n_total += 2;
    if (px !== 12'hF84) $display("FAIL sample_uniform_pixel: got %h expected F84", px); else n_pass++;
    if (pulses !== 1) $display("FAIL sample_uniform_pulses: got %0d expected 1", pulses); else n_pass++;
    feed(1'b1, 11'd27, 10'd15, 12'h000, 12'h000, 12'hFFF, 12'hFFF, pulses, px);
    n_total += 2;
    if (px !== 12'h777) $display("FAIL sample_mixed_pixel: got %h expected 777", px); else n_pass++;
    if (pulses !== 1) $display("FAIL sample_mixed_pulses: got %0d expected 1", pulses); else n_pass++;
  endtask
  task automatic test_capture();
    int pulses;
    logic [11:0] px;
    feed(1'b1, 11'd27, 10'd15, 12'hF00, 12'hF00, 12'hF00, 12'hF00, pulses, px);
    confirm_edge();
    n_total++;
    if (state !== 2'd1) $display("FAIL first_confirm_state: got %0d expected 1", state); else n_pass++;
    cur_rad = 7'd20;
    confirm_edge();
    n_total += 3;
    if (state !== 2'd0) $display("FAIL first_store_state: got %0d expected 0", state); else n_pass++;
    if (target_valid !== 2'b01) $display("FAIL first_store_valid: got %b expected 01", target_valid); else n_pass++;
    if (active_idx !== 2'd1) $display("FAIL first_store_idx: got %0d expected 1", active_idx); else n_pass++;
    dir = 4'b0001;
    tick();
    dir = 4'b0000;
    confirm_edge();
    n_total++;
    if (state !== 2'd0) $display("FAIL confirm_after_move_state: got %0d expected 0", state); else n_pass++;
    feed(1'b1, 11'd30, 10'd15, 12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0, pulses, px);
    confirm_edge();
    cur_rad = 7'd12;
    confirm_edge();
    n_total += 5;
    if (goal_pixel !== 24'h0F0F00) $display("FAIL capture_goal_pixel: got %h expected 0f0f00", goal_pixel); else n_pass++;
    if (goal_rad !== {7'd12, 7'd20}) $display("FAIL capture_goal_rad: got %h expected %h", goal_rad, {7'd12, 7'd20}); else n_pass++;
    if (target_valid !== 2'b11) $display("FAIL capture_valid: got %b expected 11", target_valid); else n_pass++;
    if (state !== 2'd2) $display("FAIL capture_state: got %0d expected 2", state); else n_pass++;
    if (track !== 1'b1 || move !== 1'b0) $display("FAIL locked_track_move: got %b%b expected 10", track, move); else n_pass++;
  endtask
  task automatic test_run_cancel();
    int pulses;
    logic [11:0] px;
    @(negedge clk_65mhz) start = 1'b1;
    @(negedge clk_65mhz);
    n_total++;
    if (state !== 2'd3 || move !== 1'b1 || track !== 1'b1) $display("FAIL run_entry: got state %0d track %b move %b expected 3 1 1", state, track, move); else n_pass++;
    dir = 4'b0001;
    tick();
    dir = 4'b0000;
    feed(1'b1, 11'd30, 10'd15, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, pulses, px);
    n_total += 2;
    if (cursor_x !== 11'd30) $display("FAIL run_cursor_frozen: got %0d expected 30", cursor_x); else n_pass++;
    if (goal_pixel !== 24'h0F0F00 || goal_rad !== {7'd12, 7'd20}) $display("FAIL run_goals_stable: got %h/%h expected 0f0f00/%h", goal_pixel, goal_rad, {7'd12, 7'd20}); else n_pass++;
    @(negedge clk_65mhz) start = 1'b0;
    @(negedge clk_65mhz);
    n_total++;
    if (state !== 2'd2) $display("FAIL run_release_state: got %0d expected 2", state); else n_pass++;
    @(negedge clk_65mhz) start = 1'b1;
    @(negedge clk_65mhz) cancel = 1'b1;
    @(negedge clk_65mhz);
    n_total += 4;
    if (state !== 2'd0) $display("FAIL cancel_state: got %0d expected 0", state); else n_pass++;
    if (track !== 1'b0 || move !== 1'b0) $display("FAIL cancel_track_move: got %b%b expected 00", track, move); else n_pass++;
    if (target_valid !== 2'b00 || active_idx !== 2'd0) $display("FAIL cancel_valid_idx: got %b/%0d expected 00/0", target_valid, active_idx); else n_pass++;
    if (goal_pixel !== 24'h0 || goal_rad !== 14'h0) $display("FAIL cancel_goals: got %h/%h expected 0/0", goal_pixel, goal_rad); else n_pass++;
    cancel = 1'b0;
    start = 1'b0;
  endtask
  task automatic test_hold_dir();
    confirm_edge();
    n_total++;
    if (state !== 2'd1) $display("FAIL hold_entry_state: got %0d expected 1", state); else n_pass++;
    @(negedge clk_65mhz) begin confirm = 1'b1; dir = 4'b1000; end
    @(negedge clk_65mhz) begin confirm = 1'b0; dir = 4'b0000; end
    n_total += 2;
    if (state !== 2'd0) $display("FAIL hold_dir_state: got %0d expected 0", state); else n_pass++;
    if (target_valid !== 2'b00) $display("FAIL hold_dir_valid: got %b expected 00", target_valid); else n_pass++;
    confirm_edge();
    @(negedge clk_65mhz) cancel = 1'b1;
    @(negedge clk_65mhz) cancel = 1'b0;
    n_total++;
    if (state !== 2'd0 || target_valid !== 2'b00) $display("FAIL hold_cancel: got state %0d valid %b expected 0 00", state, target_valid); else n_pass++;
  endtask
  task automatic test_clamp();
    dir = 4'b1110;
    repeat (10) tick();
    n_total += 2;
    if (cursor_x !== 11'd0) $display("FAIL left_reach_x: got %0d expected 0", cursor_x); else n_pass++;
    if (cursor_y !== 10'd15) $display("FAIL updown_cancel_y: got %0d expected 15", cursor_y); else n_pass++;
    tick();
    n_total++;
    if (cursor_x !== 11'd0) $display("FAIL left_clamp_x: got %0d expected 0", cursor_x); else n_pass++;
    dir = 4'b0001;
    repeat (120) tick();
    dir = 4'b0000;
    n_total++;
    if (cursor_x !== 11'd318) $display("FAIL right_clamp_x: got %0d expected 318", cursor_x); else n_pass++;
  endtask
  initial begin
    reset = 1'b1;
    hcount = 11'd1000;
    vcount = 10'd1000;
    frame_tick = 1'b0;
    dir = 4'b0000;
    confirm = 1'b0;
    cancel = 1'b0;
    start = 1'b0;
    cam = 12'h000;
    cur_rad = 7'd0;
    test_reset();
    test_no_sample_after_reset();
    test_cursor();
    test_sample();
    test_capture();
    test_run_cancel();
    test_hold_dir();
    test_clamp();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
